completion_bus_arbiter: RTL

Shares the single completion broadcast bus between the four functional-unit classes (whichMath 0..3). Each unit hands over a finished result (ROB tag plus 65-bit value). The block buffers one result per unit, picks one per cycle round-robin, and drives it registered onto the bus. That bus feeds the ROB write port, the reservation-station wakeup logic and the decode-stage completion bypass (completionRSROBTag/completionRSROBval/robWriteEn).

---
 rtl/completion_bus_arbiter_pkg.sv | 16 +
 rtl/completion_bus_arbiter_if.sv | 24 ++
 rtl/completion_bus_arbiter_rr_pick.sv | 30 +++
 rtl/completion_bus_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/completion_bus_arbiter_pkg.sv
// Shared types and sizes for the completion bus arbiter.
// Optional feature macro used by the top: CDB_PERF_CNT_EN.
package cdb_pkg;

   localparam int NUM_REQ    = 4;
   localparam int ROBsize    = 32;
   localparam int ROBsizeLog = $clog2(ROBsize + 1);

   typedef logic [1:0] unit_idx_t;

   typedef struct packed {
      logic [ROBsizeLog-1:0] tag;
      logic [64:0]           val;
   } cdb_entry_t;

endpackage

// File: rtl/completion_bus_arbiter_if.sv
// Request and broadcast bundle between the functional units and the arbiter.
interface completion_bus_arbiter_if;
   import cdb_pkg::*;

   logic [NUM_REQ-1:0]                 req_valid_i;
   logic [NUM_REQ-1:0][ROBsizeLog-1:0] req_tag_i;
   logic [NUM_REQ-1:0][64:0]           req_val_i;
   logic [NUM_REQ-1:0]                 req_ready_o;
   logic                               cdb_valid_o;
   logic [ROBsizeLog-1:0]              cdb_tag_o;
   logic [64:0]                        cdb_val_o;
   unit_idx_t                          cdb_src_o;

   modport master (
      output req_valid_i, req_tag_i, req_val_i,
      input  req_ready_o, cdb_valid_o, cdb_tag_o, cdb_val_o, cdb_src_o
   );

   modport slave (
      input  req_valid_i, req_tag_i, req_val_i,
      output req_ready_o, cdb_valid_o, cdb_tag_o, cdb_val_o, cdb_src_o
   );

endinterface

// File: rtl/completion_bus_arbiter_rr_pick.sv
// Combinational rotate-priority selector: first valid entry at or above the pointer, wrapping.
module rr_pick
   import cdb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_hold_valid,
   input  unit_idx_t          i_rr_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output unit_idx_t          o_win,
   output logic               o_any
);

   unit_idx_t w_idx;

   // Index arithmetic relies on the 2-bit unit index wrapping at NUM_REQ = 4.
   always_comb begin
      o_any   = 1'b0;
      o_win   = i_rr_ptr;
      o_grant = '0;
      w_idx   = i_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = i_rr_ptr + unit_idx_t'(k);
         if (!o_any && i_hold_valid[w_idx]) begin
            o_any = 1'b1;
            o_win = w_idx;
         end
      end
      if (o_any) o_grant[o_win] = 1'b1;
   end

endmodule

// File: rtl/completion_bus_arbiter.sv
// Buffers one result per unit and broadcasts one per cycle, round-robin, onto the completion bus.
// CDB_PERF_CNT_EN adds broadcast and conflict-cycle counters.
module completion_bus_arbiter
   import cdb_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    flush_i,
   completion_bus_arbiter_if.slave bus,
   output logic                    err_tag0_o
`ifdef CDB_PERF_CNT_EN
   ,
   output logic [31:0]             perf_bcast_o,
   output logic [31:0]             perf_conflict_o
`endif
);

   logic [NUM_REQ-1:0]    r_hold_valid;
   cdb_entry_t            r_entry [NUM_REQ];
   unit_idx_t             r_rr_ptr;
   logic                  r_cdb_valid;
   logic [ROBsizeLog-1:0] r_cdb_tag;
   logic [64:0]           r_cdb_val;
   unit_idx_t             r_cdb_src;
   logic                  r_err_tag0;

   logic [NUM_REQ-1:0]    w_grant;
   unit_idx_t             w_win;
   logic                  w_any;
   logic [NUM_REQ-1:0]    w_ready;
   logic [NUM_REQ-1:0]    w_accept;
   logic [NUM_REQ-1:0]    w_tag_nz;
   logic [NUM_REQ-1:0]    w_load;
   logic [NUM_REQ-1:0]    w_hold_next;

   rr_pick u_rr_pick (
      .i_hold_valid (r_hold_valid),
      .i_rr_ptr     (r_rr_ptr),
      .o_grant      (w_grant),
      .o_win        (w_win),
      .o_any        (w_any)
   );

   // Tag 0 is accepted to keep the unit moving but never occupies an entry.
   always_comb begin
      w_tag_nz = '0;
      for (int i = 0; i < NUM_REQ; i++) w_tag_nz[i] = |bus.req_tag_i[i];
      w_ready     = {NUM_REQ{~flush_i}} & (~r_hold_valid | w_grant);
      w_accept    = bus.req_valid_i & w_ready;
      w_load      = w_accept & w_tag_nz;
      w_hold_next = {NUM_REQ{~flush_i}} & ((r_hold_valid & ~w_grant) | w_load);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_hold_valid <= '0;
         for (int i = 0; i < NUM_REQ; i++) r_entry[i] <= '0;
         r_rr_ptr     <= '0;
         r_cdb_valid  <= 1'b0;
         r_cdb_tag    <= '0;
         r_cdb_val    <= '0;
         r_cdb_src    <= '0;
         r_err_tag0   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_load[i]) begin
               r_entry[i].tag <= bus.req_tag_i[i];
               r_entry[i].val <= bus.req_val_i[i];
            end
         end
         r_hold_valid <= w_hold_next;
         if (|(w_accept & ~w_tag_nz)) r_err_tag0 <= 1'b1;
         if (flush_i) begin
            r_cdb_valid <= 1'b0;
            r_rr_ptr    <= '0;
         end else if (w_any) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_entry[w_win].tag;
            r_cdb_val   <= r_entry[w_win].val;
            r_cdb_src   <= w_win;
            r_rr_ptr    <= w_win + 2'd1;
         end else begin
            r_cdb_valid <= 1'b0;
         end
      end
   end

`ifdef CDB_PERF_CNT_EN
   logic [31:0] r_perf_bcast;
   logic [31:0] r_perf_conflict;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_perf_bcast    <= '0;
         r_perf_conflict <= '0;
      end else begin
         if (w_any && !flush_i)         r_perf_bcast    <= r_perf_bcast + 32'd1;
         if ($countones(r_hold_valid) >= 2) r_perf_conflict <= r_perf_conflict + 32'd1;
      end
   end

   assign perf_bcast_o    = r_perf_bcast;
   assign perf_conflict_o = r_perf_conflict;
`endif

   assign bus.req_ready_o = w_ready;
   assign bus.cdb_valid_o = r_cdb_valid;
   assign bus.cdb_tag_o   = r_cdb_tag;
   assign bus.cdb_val_o   = r_cdb_val;
   assign bus.cdb_src_o   = r_cdb_src;
   assign err_tag0_o      = r_err_tag0;

endmodule
